// File: rtl/shift_sequencer.sv
// Command front-end for the 4-bit barrel_shifter: breaks a wide shift/rotate
// into steps of at most STEP_MAX positions, looping bs_dout back into acc_q.
module shift_sequencer #(
    parameter int AMT_W    = 4,
    parameter int STEP_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_select,
    input  logic             cmd_direction,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic [3:0]       cmd_data,
    output logic             bs_select,
    output logic             bs_direction,
    output logic [1:0]       bs_shift_value,
    output logic [3:0]       bs_din,
    input  logic [3:0]       bs_dout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A plain shift by four or more clears the nibble, so the amount saturates
    // at 4; a 2-bit amount can never reach that, hence the narrower clamp.
    localparam int               CLAMP_AMT  = (AMT_W > 2) ? 4 : 3;
    localparam logic [AMT_W-1:0] CLAMP_W    = AMT_W'(CLAMP_AMT);
    localparam logic [AMT_W-1:0] STEP_MAX_W = AMT_W'(STEP_MAX);
    localparam logic [1:0]       STEP_MAX_2 = 2'(STEP_MAX);

    state_t           state_q, state_d;
    logic [3:0]       acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             sel_q, sel_d;
    logic             dir_q, dir_d;

    logic [AMT_W-1:0] remNorm;
    logic [1:0]       step2;
    logic [AMT_W-1:0] stepW;
    logic             accept;

    always_comb begin
        remNorm = '0;
        if (cmd_select) begin
            remNorm = AMT_W'(cmd_amount[1:0]);
        end else if (32'(cmd_amount) >= 32'(CLAMP_AMT)) begin
            remNorm = CLAMP_W;
        end else begin
            remNorm = cmd_amount;
        end
    end

    always_comb begin
        step2 = (rem_q > STEP_MAX_W) ? STEP_MAX_2 : rem_q[1:0];
        stepW = AMT_W'(step2);
    end

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            sel_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_d   = cmd_select;
                    dir_d   = cmd_direction;
                    acc_d   = cmd_data;
                    rem_d   = remNorm;
                    state_d = (remNorm == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                acc_d = bs_dout;
                rem_d = rem_q - stepW;
                if (rem_q == stepW) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // cmd_ready is gated by rst so nothing can be taken while reset is held.
    always_comb begin
        cmd_ready      = (state_q == IDLE) && !rst;
        res_valid      = (state_q == DONE);
        busy           = (state_q != IDLE);
        res_data       = acc_q;
        bs_select      = sel_q;
        bs_direction   = dir_q;
        bs_din         = acc_q;
        bs_shift_value = (state_q == RUN) ? step2 : 2'd0;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Sequential command front-end that sits directly upstream of the 4-bit barrel_shifter and drives its select/direction/shift_value/din inputs.
- Accepts shift/rotate commands with amounts wider than 2 bits through a valid/ready handshake.
- Breaks each command into steps of at most 3 positions, feeding each step's barrel_shifter dout back into an accumulator register.
- Presents the final 4-bit result on a valid/ready output.

Parameters:
AMT_W, 4, width of cmd_amount; legal range is 2 to 8.
STEP_MAX, 3, largest per-cycle step issued on bs_shift_value; legal range is 1 to 3.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_select  input  1  0 = shift, 1 = rotate.
cmd_direction  input  1  0 = right, 1 = left.
cmd_amount  input  AMT_W  total positions to move.
cmd_data  input  4  operand.
bs_select  output  1  to barrel_shifter select.
bs_direction  output  1  to barrel_shifter direction.
bs_shift_value  output  2  to barrel_shifter shift_value.
bs_din  output  4  to barrel_shifter din.
bs_dout  input  4  from barrel_shifter dout (combinational return path).
res_valid  output  1  result present.
res_ready  input  1  consumer accepts the result.
res_data  output  4  final result.
busy  output  1  high in RUN or DONE.

Behaviour:
- Registers: state, acc[3:0], rem[AMT_W-1:0], sel_q, dir_q.
- FSM states: IDLE, RUN, DONE.
- Reset (async, rst=1):
  - state=IDLE, acc=0, rem=0, sel_q=0, dir_q=0.
  - cmd_ready=0 and res_valid=0 while rst is high; busy=0.
  - Reset mid-RUN or mid-DONE aborts the command and drops the result with no output.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch sel_q, dir_q, acc=cmd_data.
  - Normalise the amount: rotate gives rem=cmd_amount mod 4; shift gives rem=min(cmd_amount,4), since 4 or more positions yields 0.
  - If the normalised rem=0, go to DONE; otherwise go to RUN.
- RUN:
  - step = min(rem, STEP_MAX), driven on bs_shift_value.
  - Each clock: acc<=bs_dout, rem<=rem-step.
  - When rem==step, go to DONE.
  - RUN lasts ceil(rem_normalised/STEP_MAX) cycles; cmd_valid is ignored.
- DONE:
  - res_valid=1, res_data=acc.
  - res_data stays stable until res_valid&&res_ready; then go to IDLE on that edge.
  - No combinational path from res_ready to cmd_ready; a new command is accepted no earlier than the cycle after the result handshake.
- bs_* outputs are driven from registers only:
  - bs_select=sel_q, bs_direction=dir_q, bs_din=acc.
  - bs_shift_value=step in RUN and 0 in IDLE/DONE.
- res_data=acc in all states; it is meaningful only while res_valid=1.
- busy = state!=IDLE.
- Latency from the command-accept edge to res_valid high:
  - 1 cycle for rem=0.
  - 1 + number of RUN cycles otherwise.
  - With STEP_MAX=3 the maximum is 3 cycles (shift, rem=4).
- A simultaneous cmd_valid in DONE is not accepted and no flag is raised.
- res_ready held high continuously gives back-to-back throughput of one command per (latency + 1) cycles.

Test Plan:
- Rotate right (select=1, direction=0), amount=5, data=4'b0001 -> rem=1, one RUN cycle with bs_shift_value=1; res_valid 2 cycles after accept; res_data=4'b1000.
- Rotate left, amount=7, data=4'b0110 -> rem=3, single step; res_data=4'b0011.
- Shift left (select=0, direction=1), amount=5, data=4'b1011 -> clamp to 4; steps 3 then 1, with acc=4'b1000 after the first step; res_data=4'b0000 at 3 cycles.
- Shift right, amount=0, data=4'b1101 -> no RUN state, res_valid the cycle after accept, res_data=4'b1101, bs_shift_value stays 0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while pulsing cmd_valid -> res_valid/res_data stable, cmd_ready=0, command not taken; after the handshake, cmd_ready=1 the next cycle.
- Assert rst during RUN of a shift-left-4 -> state=IDLE, res_valid=0 immediately (async), acc=0; no result is emitted after rst deasserts.
